// File: rtl/rfsoc_pl_ctrl_pkg.sv
// Shared types and constants for the PL controller ADC capture path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rfsoc_pl_ctrl_pkg;

    localparam int SAMPLES_PER_BEAT = 8;
    localparam int SAMPLE_W         = 16;
    localparam int ADC_AXIS_W       = 128;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } cap_state_e;

    // True when any signed sample in the beat is strictly above the threshold.
    function automatic logic beat_above(input logic [ADC_AXIS_W-1:0] beat,
                                        input logic [SAMPLE_W-1:0]   thr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < SAMPLES_PER_BEAT; i++) begin
            if ($signed(beat[i*SAMPLE_W +: SAMPLE_W]) > $signed(thr)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/adc_capture_buf_if.sv
// 128-bit valid/ready stream bundle used on both sides of the capture buffer.
// Latency: n/a (wires only).
// Backpressure: tready from the sink; data must hold while tvalid && !tready.
// Ports: tdata (beat), tvalid (beat present), tready (sink accepts).
interface adc_capture_buf_if;
    import rfsoc_pl_ctrl_pkg::*;

    logic [ADC_AXIS_W-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input  tready);
    modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/adc_capture_fifo.sv
// First-word-fall-through FIFO holding captured ADC beats.
// Latency: a write at edge k is visible on rd_dat after edge k.
// Backpressure: writes while full and reads while empty are ignored.
// Ports: clk/rst (async active-low), wr_en/wr_dat, rd_en/rd_dat, full, empty, count.
module adc_capture_fifo
    import rfsoc_pl_ctrl_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int W     = ADC_AXIS_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_dat,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt_q;
    logic          do_wr;
    logic          do_rd;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

    // Full/empty are taken from the current count, so a write into a full
    // FIFO is dropped even if a read frees a slot on the same edge.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Head is masked to zero while empty so the output is defined in reset.
    assign rd_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/adc_capture_buf.sv
// Triggered ADC capture buffer: arm, wait for sw/threshold trigger, store N beats, forward.
// Latency: one cycle from captured input beat to m_axis (FWFT FIFO).
// Backpressure: input is never stalled; captured beats arriving while full are dropped (overflow).
// Ports: clk, rst (async active-low), arm/sw_trig/thresh_en/thresh/cap_len control,
//        s_axis (ADC in), m_axis + m_axis_tlast (controller out), state, done, overflow.
module adc_capture_buf
    import rfsoc_pl_ctrl_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm,
    input  logic                 sw_trig,
    input  logic                 thresh_en,
    input  logic [SAMPLE_W-1:0]  thresh,
    input  logic [LEN_W-1:0]     cap_len,
    adc_capture_buf_if.slave     s_axis,
    adc_capture_buf_if.master    m_axis,
    output logic                 m_axis_tlast,
    output logic [1:0]           state,
    output logic                 done,
    output logic                 overflow
);
    localparam int CW = $clog2(DEPTH) + 1;

    cap_state_e       state_q;
    cap_state_e       state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic             s_rdy_q;
    logic             done_q;
    logic             ovf_q;

    logic             trig_hit;
    logic             arm_ok;
    logic             cnt_last;
    logic             cap_beat;
    logic             wr_en;
    logic             tlast;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [ADC_AXIS_W-1:0] head_dat;
    logic             rd_en;

    assign trig_hit = s_axis.tvalid &&
                      (sw_trig || (thresh_en && beat_above(s_axis.tdata, thresh)));
    assign arm_ok   = (state_q == ST_IDLE) && arm;
    // The incoming beat is the one that completes the programmed length.
    assign cnt_last = ((cnt_q + LEN_W'(1)) == len_q);

    // ---- state register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- next state ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arm && (cap_len != '0)) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (trig_hit) begin
                    state_d = (len_q == LEN_W'(1)) ? ST_DRAIN : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (s_axis.tvalid && cnt_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---- outputs / datapath strobes ----
    always_comb begin
        cap_beat = 1'b0;
        tlast    = 1'b0;
        case (state_q)
            ST_ARMED:   cap_beat = trig_hit;
            ST_CAPTURE: cap_beat = s_axis.tvalid;
            ST_DRAIN:   tlast    = (fifo_count == CW'(1));
            default:    cap_beat = 1'b0;
        endcase
        wr_en = cap_beat && !fifo_full;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q   <= '0;
            cnt_q   <= '0;
            s_rdy_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            s_rdy_q <= 1'b1;
            if (arm_ok && (cap_len != '0)) begin
                len_q <= cap_len;
            end
            if ((state_q == ST_ARMED) && trig_hit) begin
                cnt_q <= LEN_W'(1);
            end else if ((state_q == ST_CAPTURE) && s_axis.tvalid) begin
                cnt_q <= cnt_q + LEN_W'(1);
            end
            // Dropped beats still count toward the length; only the flag records them.
            if (arm_ok) begin
                ovf_q <= 1'b0;
            end else if (cap_beat && fifo_full) begin
                ovf_q <= 1'b1;
            end
            done_q <= (arm_ok && (cap_len == '0)) ||
                      ((state_q == ST_DRAIN) && fifo_empty);
        end
    end

    assign rd_en = !fifo_empty && m_axis.tready;

    adc_capture_fifo #(
        .DEPTH (DEPTH),
        .W     (ADC_AXIS_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_dat (s_axis.tdata),
        .rd_en  (rd_en),
        .rd_dat (head_dat),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign s_axis.tready = s_rdy_q;
    assign m_axis.tdata  = head_dat;
    assign m_axis.tvalid = !fifo_empty;
    assign m_axis_tlast  = tlast;
    assign state         = state_q;
    assign done          = done_q;
    assign overflow      = ovf_q;
endmodule

// File: tb/tb_adc_capture_buf.sv
module tb_adc_capture_buf;
    localparam int DEPTH = 64;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             arm;
    logic             sw_trig;
    logic             thresh_en;
    logic [15:0]      thresh;
    logic [LEN_W-1:0] cap_len;
    logic             m_tlast;
    logic [1:0]       state;
    logic             done;
    logic             overflow;

    adc_capture_buf_if s_if ();
    adc_capture_buf_if m_if ();

    always #5 clk = ~clk;

    adc_capture_buf #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst          (rst_n),
        .arm          (arm),
        .sw_trig      (sw_trig),
        .thresh_en    (thresh_en),
        .thresh       (thresh),
        .cap_len      (cap_len),
        .s_axis       (s_if.slave),
        .m_axis       (m_if.master),
        .m_axis_tlast (m_tlast),
        .state        (state),
        .done         (done),
        .overflow     (overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---- output monitor: handshakes, done pulses, stall stability ----
    int           cyc = 0;
    logic [127:0] rx_dat[$];
    logic         rx_last[$];
    int           done_cnt = 0;
    int           done_cyc = -1;
    int           last_cyc = -1;
    logic [1:0]   done_state = 2'd0;
    logic         stall_p = 1'b0;
    logic [127:0] stall_dat = '0;
    logic         stall_last = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (stall_p) begin
                n_cmp++;
                if (!(m_if.tvalid && m_if.tdata == stall_dat && m_tlast == stall_last)) begin
                    n_bad++;
                    $display("FAIL stall_hold: got v=%0b d=%0h l=%0b want d=%0h l=%0b",
                             m_if.tvalid, m_if.tdata, m_tlast, stall_dat, stall_last);
                end
            end
            if (m_if.tvalid && m_if.tready) begin
                rx_dat.push_back(m_if.tdata);
                rx_last.push_back(m_tlast);
                if (m_tlast) last_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc   = cyc;
                done_state = state;
            end
            stall_p    = m_if.tvalid && !m_if.tready;
            stall_dat  = m_if.tdata;
            stall_last = m_tlast;
        end else begin
            stall_p = 1'b0;
        end
    end

    task automatic clear_mon();
        rx_dat.delete();
        rx_last.delete();
        done_cnt = 0;
        done_cyc = -1;
        last_cyc = -1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        arm = 1'b0;
        sw_trig = 1'b0;
        s_if.tvalid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_mon();
    endtask

    // Keep the ADC streaming incrementing data until done or the bound expires.
    task automatic feed_until_done(input int max_cyc, input logic toggle_rdy);
        for (int i = 0; i < max_cyc; i++) begin
            if (done_cnt != 0) break;
            s_if.tdata = s_if.tdata + 128'd1;
            if (toggle_rdy) m_if.tready = ~m_if.tready;
            tick();
        end
        chk("done_seen", done_cnt, 1);
        m_if.tready = 1'b1;
    endtask

    task automatic chk_stream(input string nm, input int n, input logic [127:0] first);
        chk({nm, "_len"}, rx_dat.size(), n);
        for (int i = 0; i < n && i < rx_dat.size(); i++) begin
            chk({nm, "_dat"}, rx_dat[i], first + 128'(i));
            chk({nm, "_last"}, rx_last[i], (i == n - 1) ? 1'b1 : 1'b0);
        end
    endtask

    function automatic logic [127:0] mk(input int idx, input logic [15:0] val, input logic [15:0] fill);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = (i == idx) ? val : fill;
        return r;
    endfunction

    typedef struct {
        logic [15:0]  thr;
        logic         en;
        logic [127:0] dat;
        logic [1:0]   exp_state;
        logic         exp_vld;
    } tvec_t;

    tvec_t tv [8];

    initial begin
        rst_n = 1'b0;
        arm = 1'b0;
        sw_trig = 1'b0;
        thresh_en = 1'b0;
        thresh = '0;
        cap_len = '0;
        s_if.tdata = '0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;

        tv[0] = '{16'd1000, 1'b1, mk(5, 16'd1001, 16'd0),      2'd3, 1'b1};
        tv[1] = '{16'd1000, 1'b1, mk(5, 16'd1000, 16'd0),      2'd1, 1'b0};
        tv[2] = '{16'd1000, 1'b1, mk(2, 16'hF830, 16'd0),      2'd1, 1'b0};
        tv[3] = '{16'hFF9C, 1'b1, mk(0, 16'hFF9D, 16'h8000),   2'd3, 1'b1};
        tv[4] = '{16'hFF9C, 1'b1, mk(0, 16'hFF9C, 16'h8000),   2'd1, 1'b0};
        tv[5] = '{16'd0,    1'b1, mk(7, 16'h7FFF, 16'h8000),   2'd3, 1'b1};
        tv[6] = '{16'h7FFF, 1'b1, mk(0, 16'h7FFF, 16'h7FFF),   2'd1, 1'b0};
        tv[7] = '{16'd0,    1'b0, mk(3, 16'h7FFF, 16'h7FFF),   2'd1, 1'b0};

        // ---- reset values ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_tready", s_if.tready, 0);
        chk("rst_m_tvalid", m_if.tvalid, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_tdata", m_if.tdata, 0);
        chk("rst_state", state, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        tick();
        chk("s_tready_rise", s_if.tready, 1);
        clear_mon();

        // ---- software trigger, length 4 ----
        m_if.tready = 1'b1;
        arm = 1'b1; cap_len = 16'd4; s_if.tvalid = 1'b1; s_if.tdata = 128'd100;
        tick();
        arm = 1'b0;
        chk("sw_armed", state, 1);
        chk("sw_no_pre_beat", m_if.tvalid, 0);
        sw_trig = 1'b1; s_if.tdata = 128'd101;
        tick();
        sw_trig = 1'b0;
        chk("sw_capture", state, 2);
        chk("sw_first_vld", m_if.tvalid, 1);
        chk("sw_first_dat", m_if.tdata, 128'd101);
        feed_until_done(40, 1'b0);
        chk_stream("sw", 4, 128'd101);
        chk("sw_done_delay", done_cyc - last_cyc, 2);
        chk("sw_done_state", done_state, 0);
        tick();
        chk("sw_done_once", done, 0);
        chk("sw_idle", state, 0);

        // ---- threshold trigger table ----
        for (int v = 0; v < 8; v++) begin
            apply_reset();
            thresh = tv[v].thr;
            thresh_en = tv[v].en;
            m_if.tready = 1'b0;
            arm = 1'b1; cap_len = 16'd1;
            tick();
            arm = 1'b0;
            s_if.tvalid = 1'b1; s_if.tdata = tv[v].dat;
            tick();
            s_if.tvalid = 1'b0;
            chk($sformatf("thr%0d_state", v), state, tv[v].exp_state);
            chk($sformatf("thr%0d_vld", v), m_if.tvalid, tv[v].exp_vld);
            chk($sformatf("thr%0d_last", v), m_tlast, tv[v].exp_vld);
            if (tv[v].exp_vld) chk($sformatf("thr%0d_dat", v), m_if.tdata, tv[v].dat);
        end
        thresh_en = 1'b0;

        // ---- overflow with output stalled ----
        apply_reset();
        m_if.tready = 1'b0;
        arm = 1'b1; cap_len = 16'd70; s_if.tvalid = 1'b1; s_if.tdata = 128'd1000;
        tick();
        arm = 1'b0;
        sw_trig = 1'b1; s_if.tdata = 128'd1001;
        tick();
        sw_trig = 1'b0;
        for (int i = 0; i < 75; i++) begin
            s_if.tdata = s_if.tdata + 128'd1;
            tick();
        end
        chk("ovf_state", state, 3);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", m_if.tdata, 128'd1001);
        chk("ovf_no_last", m_tlast, 0);
        m_if.tready = 1'b1;
        feed_until_done(200, 1'b0);
        chk_stream("ovf", 64, 128'd1001);
        chk("ovf_sticky", overflow, 1);
        s_if.tvalid = 1'b0;
        tick();

        // ---- zero length arm ----
        clear_mon();
        arm = 1'b1; cap_len = 16'd0;
        tick();
        arm = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_state", state, 0);
        chk("zero_ovf_clr", overflow, 0);
        tick();
        chk("zero_done_pulse", done, 0);
        chk("zero_no_out", rx_dat.size(), 0);

        // ---- arm ignored during capture ----
        clear_mon();
        m_if.tready = 1'b1;
        arm = 1'b1; cap_len = 16'd6; s_if.tvalid = 1'b1; s_if.tdata = 128'd2000;
        tick();
        arm = 1'b0;
        sw_trig = 1'b1; s_if.tdata = 128'd2001;
        tick();
        sw_trig = 1'b0; s_if.tdata = 128'd2002;
        tick();
        chk("iarm_capture", state, 2);
        arm = 1'b1; cap_len = 16'd2; s_if.tdata = 128'd2003;
        tick();
        arm = 1'b0; cap_len = 16'd0;
        feed_until_done(40, 1'b0);
        chk_stream("iarm", 6, 128'd2001);

        // ---- reset mid-capture ----
        clear_mon();
        m_if.tready = 1'b0;
        arm = 1'b1; cap_len = 16'd10; s_if.tvalid = 1'b1; s_if.tdata = 128'd3000;
        tick();
        arm = 1'b0;
        sw_trig = 1'b1; s_if.tdata = 128'd3001;
        tick();
        sw_trig = 1'b0; s_if.tdata = 128'd3002;
        tick();
        s_if.tdata = 128'd3003;
        tick();
        chk("mrst_capture", state, 2);
        chk("mrst_buffered", m_if.tvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_vld", m_if.tvalid, 0);
        chk("mrst_state", state, 0);
        chk("mrst_s_tready", s_if.tready, 0);
        tick();
        rst_n = 1'b1;
        s_if.tvalid = 1'b0;
        repeat (5) tick();
        chk("mrst_no_done", done_cnt, 0);
        chk("mrst_state_after", state, 0);
        chk("mrst_no_out", m_if.tvalid, 0);

        // ---- concurrent drain, ready toggling ----
        clear_mon();
        m_if.tready = 1'b1;
        arm = 1'b1; cap_len = 16'd100; s_if.tvalid = 1'b1; s_if.tdata = 128'd4000;
        tick();
        arm = 1'b0;
        sw_trig = 1'b1; s_if.tdata = 128'd4001;
        tick();
        sw_trig = 1'b0;
        feed_until_done(400, 1'b1);
        chk_stream("conc", 100, 128'd4001);
        chk("conc_ovf", overflow, 0);
        s_if.tvalid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
